// File: rtl/button_arbiter4.sv
// Four-button round-robin arbiter: grants one pressed button, holds it for a
// fixed time, waits for its release, then enforces a cooldown before re-arming.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; any press is granted round-robin at the next edge
// HOLD    | owner granted; OUTBTN forced high for 2^TIMERW cycles
// WAITREL | hold time over; waiting for the owner to release its button
// COOL    | owner released; all presses ignored for 2^TIMERW cycles
module button_arbiter4 #(
    parameter int TIMERW = 4
) (
    input  logic       IPTCLK,
    input  logic       IPTNRST,
    input  logic [3:0] IPTBTN,
    output logic [3:0] OUTBTN,
    output logic [3:0] OUTPLS,
    output logic [1:0] OUTID,
    output logic       OUTBUSY
);

    localparam logic [TIMERW-1:0] TMR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        WAITREL = 2'd2,
        COOL    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [TIMERW-1:0] tmr, tmr_nxt;
    logic [3:0]        btn_q, btn_nxt;
    logic [3:0]        pls_q, pls_nxt;
    logic [1:0]        id_q, id_nxt;
    logic [1:0]        last_q, last_nxt;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;

    // Search starts just after the previous owner so every button gets a turn.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && IPTBTN[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge IPTCLK or negedge IPTNRST) begin
        if (!IPTNRST) begin
            state  <= IDLE;
            tmr    <= '0;
            btn_q  <= '0;
            pls_q  <= '0;
            id_q   <= 2'd0;
            last_q <= 2'd3;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            btn_q  <= btn_nxt;
            pls_q  <= pls_nxt;
            id_q   <= id_nxt;
            last_q <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        btn_nxt   = btn_q;
        pls_nxt   = '0;
        id_nxt    = id_q;
        last_nxt  = last_q;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (found) begin
                    state_nxt = HOLD;
                    id_nxt    = winner;
                    last_nxt  = winner;
                    btn_nxt   = 4'b0001 << winner;
                    pls_nxt   = 4'b0001 << winner;
                end
            end
            HOLD: begin
                // Reaching MAX ends the hold instead of wrapping the timer.
                if (tmr == TMR_MAX) state_nxt = WAITREL;
                else                tmr_nxt   = tmr + 1'b1;
            end
            WAITREL: begin
                if (!IPTBTN[id_q]) begin
                    btn_nxt   = '0;
                    tmr_nxt   = '0;
                    state_nxt = COOL;
                end
            end
            COOL: begin
                if (tmr == TMR_MAX) begin
                    tmr_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
                btn_nxt   = '0;
            end
        endcase
    end

    assign OUTBTN  = btn_q;
    assign OUTPLS  = pls_q;
    assign OUTID   = id_q;
    assign OUTBUSY = (state != IDLE);

endmodule

// File: tb/tb_button_arbiter4.sv
// Bench for button_arbiter4: two instances (TIMERW=4 and TIMERW=2) checked every
// cycle against a phase/countdown reference model, plus directed scenarios.
module tb_button_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn4, btn2;
    logic [3:0] outbtn4, outpls4, outbtn2, outpls2;
    logic [1:0] outid4, outid2;
    logic       outbusy4, outbusy2;

    int vectors = 0;
    int miscompares = 0;

    button_arbiter4 #(.TIMERW(4)) dut4 (
        .IPTCLK (clk), .IPTNRST(rst_n), .IPTBTN(btn4),
        .OUTBTN (outbtn4), .OUTPLS(outpls4), .OUTID(outid4), .OUTBUSY(outbusy4)
    );

    button_arbiter4 #(.TIMERW(2)) dut2 (
        .IPTCLK (clk), .IPTNRST(rst_n), .IPTBTN(btn2),
        .OUTBTN (outbtn2), .OUTPLS(outpls2), .OUTID(outid2), .OUTBUSY(outbusy2)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_HOLD, M_WAIT, M_COOL} mphase_t;
    typedef struct {
        mphase_t ph;
        int      left;
        int      owner;
        int      last;
        bit      pls;
    } model_t;

    model_t m4, m2;

    function automatic model_t mreset();
        model_t r;
        r.ph = M_IDLE; r.left = 0; r.owner = 0; r.last = 3; r.pls = 1'b0;
        return r;
    endfunction

    // p = length in cycles of both the hold and the cooldown phases
    function automatic model_t mstep(model_t m, logic [3:0] b, int p);
        model_t r = m;
        bit     done = 1'b0;
        r.pls = 1'b0;
        case (m.ph)
            M_IDLE: begin
                for (int k = 1; k <= 4; k++) begin
                    int i = (m.last + k) % 4;
                    if (!done && b[i]) begin
                        done = 1'b1;
                        r.owner = i; r.last = i; r.ph = M_HOLD; r.left = p; r.pls = 1'b1;
                    end
                end
            end
            M_HOLD: begin
                r.left = m.left - 1;
                if (r.left == 0) r.ph = M_WAIT;
            end
            M_WAIT: if (!b[m.owner]) begin r.ph = M_COOL; r.left = p; end
            M_COOL: begin
                r.left = m.left - 1;
                if (r.left == 0) r.ph = M_IDLE;
            end
            default: r = mreset();
        endcase
        return r;
    endfunction

    function automatic int exp_btn(model_t m);
        return (m.ph == M_HOLD || m.ph == M_WAIT) ? (1 << m.owner) : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("btn4",  32'(outbtn4),  32'(exp_btn(m4)));
        check_val("pls4",  32'(outpls4),  m4.pls ? 32'(1 << m4.owner) : 32'd0);
        check_val("id4",   32'(outid4),   32'(m4.owner));
        check_val("busy4", 32'(outbusy4), 32'(m4.ph != M_IDLE));
        check_val("btn2",  32'(outbtn2),  32'(exp_btn(m2)));
        check_val("pls2",  32'(outpls2),  m2.pls ? 32'(1 << m2.owner) : 32'd0);
        check_val("id2",   32'(outid2),   32'(m2.owner));
        check_val("busy2", 32'(outbusy2), 32'(m2.ph != M_IDLE));
    endtask

    task automatic tick();
        @(posedge clk);
        m4 = mstep(m4, btn4, 16);
        m2 = mstep(m2, btn2, 4);
        @(negedge clk);
        compare_all();
    endtask

    // Called from a falling edge; reset lands mid-cycle, released one cycle later.
    task automatic do_async_reset();
        #2;
        rst_n = 1'b0;
        m4 = mreset();
        m2 = mreset();
        #1;
        check_val("rst_btn4",  32'(outbtn4),  32'd0);
        check_val("rst_busy4", 32'(outbusy4), 32'd0);
        check_val("rst_pls4",  32'(outpls4),  32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        int cb4, cy4, cp4, cb2, cy2, cp2;
        int seen;
        rst_n = 1'b0;
        btn4 = '0;
        btn2 = '0;
        m4 = mreset();
        m2 = mreset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Single one-cycle press: measure grant pulse, held and busy durations.
        btn4 = 4'b0100;
        btn2 = 4'b0100;
        tick();
        check_val("grant_pls_btn2", 32'(outpls4), 32'h4);
        check_val("grant_id_btn2",  32'(outid4),  32'd2);
        btn4 = '0;
        btn2 = '0;
        cb4 = 1; cy4 = 1; cp4 = 1; cb2 = 1; cy2 = 1; cp2 = 1;
        repeat (40) begin
            tick();
            cb4 += (outbtn4 != 0) ? 1 : 0;
            cy4 += outbusy4 ? 1 : 0;
            cp4 += (outpls4 != 0) ? 1 : 0;
            cb2 += (outbtn2 != 0) ? 1 : 0;
            cy2 += outbusy2 ? 1 : 0;
            cp2 += (outpls2 != 0) ? 1 : 0;
        end
        check_val("w4_btn_cycles",  32'(cb4), 32'd17);
        check_val("w4_busy_cycles", 32'(cy4), 32'd33);
        check_val("w4_pls_cycles",  32'(cp4), 32'd1);
        check_val("w2_btn_cycles",  32'(cb2), 32'd5);
        check_val("w2_cool_cycles", 32'(cy2 - cb2), 32'd4);
        check_val("w2_pls_cycles",  32'(cp2), 32'd1);

        // Long press: output follows the owner until release.
        btn4 = 4'b0010;
        btn2 = 4'b0010;
        repeat (40) tick();
        check_val("long_hold_btn", 32'(outbtn4), 32'h2);
        btn4 = '0;
        btn2 = '0;
        repeat (20) tick();

        // All buttons held across three grants: rotation from reset order.
        do_async_reset();
        btn4 = 4'b1111;
        btn2 = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            seen = 0;
            for (int t = 0; t < 60 && seen == 0; t++) begin
                tick();
                if (outpls4 != 0) seen = 1;
            end
            check_val("rr_grant_seen", 32'(seen), 32'd1);
            check_val("rr_winner", 32'(outid4), 32'(g));
            repeat (16) tick();
            btn4 = '0;
            btn2 = '0;
            tick();
            btn4 = 4'b1111;
            btn2 = 4'b1111;
        end
        btn4 = '0;
        btn2 = '0;
        repeat (40) tick();

        // Non-owner press during hold is neither granted nor queued.
        do_async_reset();
        btn4 = 4'b0001;
        btn2 = 4'b0001;
        repeat (2) tick();
        btn4 = 4'b1001;
        btn2 = 4'b1001;
        repeat (10) begin
            tick();
            check_val("nonowner_btn", 32'(outbtn4), 32'h1);
        end
        btn4 = 4'b0001;
        btn2 = 4'b0001;
        repeat (10) tick();
        btn4 = '0;
        btn2 = '0;
        cp4 = 0;
        repeat (40) begin
            tick();
            cp4 += (outpls4 != 0) ? 1 : 0;
        end
        check_val("nonowner_no_grant", 32'(cp4), 32'd0);

        // Reset between edges mid-hold, then a held btn3 is granted next edge.
        do_async_reset();
        btn4 = 4'b0001;
        btn2 = 4'b0001;
        tick();
        repeat (7) tick();
        btn4 = 4'b1000;
        btn2 = 4'b1000;
        do_async_reset();
        tick();
        check_val("post_rst_btn3", 32'(outbtn4), 32'h8);
        check_val("post_rst_pls3", 32'(outpls4), 32'h8);
        btn4 = '0;
        btn2 = '0;
        repeat (40) tick();

        // Randomized traffic with occasional asynchronous resets.
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) btn4 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) btn2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) do_async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_arbiter4.md
BUTTON_ARBITER4 -- requirements
Module: button_arbiter4

Interface
REQ-001 SHALL have parameter TIMERW, default 4: width of the shared hold/cooldown timer; legal range 2..8.
REQ-002 SHALL have port IPTCLK, input, 1: device clock; all state changes on its rising edge.
REQ-003 SHALL have port IPTNRST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port IPTBTN, input, 4: raw button levels, bit i = button i pressed.
REQ-005 SHALL have port OUTBTN, output, 4: one-hot held level of the granted button; all zero when no owner.
REQ-006 SHALL have port OUTPLS, output, 4: one-hot single-cycle pulse marking a new grant.
REQ-007 SHALL have port OUTID, output, 2: index of the current or most recent owner.
REQ-008 SHALL have port OUTBUSY, output, 1: high whenever state is not IDLE.

Function
REQ-009 SHALL share one TIMERW-bit up-counter (TMR) among all four buttons; MAX = 2^TIMERW-1.
REQ-010 SHALL implement FSM states IDLE, HOLD, WAITREL, COOL; all outputs except OUTBUSY registered.
REQ-011 IDLE: SHALL keep TMR=0; if IPTBTN != 0 at an edge, SHALL grant one button at that edge and enter HOLD.
REQ-012 Grant choice SHALL be round-robin: search order LAST+1, LAST+2, LAST+3, LAST (mod 4); the first pressed index wins.
REQ-013 On grant SHALL load OUTID and LAST with the winner, set OUTBTN[winner]=1, set OUTPLS[winner]=1 for exactly one cycle, TMR=0.
REQ-014 Latency: press present before edge k SHALL produce OUTBTN/OUTPLS high in cycle following edge k (1 cycle).
REQ-015 HOLD: each edge, SHALL increment TMR if TMR<MAX, else enter WAITREL; HOLD lasts exactly 2^TIMERW cycles.
REQ-016 HOLD SHALL ignore owner release; OUTBTN stays high (minimum high time 2^TIMERW+1 cycles).
REQ-017 WAITREL: if IPTBTN[OUTID]=0 at an edge, SHALL clear OUTBTN, TMR=0, enter COOL; otherwise stay.
REQ-018 COOL: each edge, SHALL increment TMR if TMR<MAX, else TMR=0 and enter IDLE; COOL lasts exactly 2^TIMERW cycles.
REQ-019 Presses of any button in HOLD, WAITREL, COOL SHALL be ignored and not queued; a button still held on return to IDLE SHALL be eligible for grant.
REQ-020 Non-owner buttons SHALL never affect TMR, state, or OUTBTN.
REQ-021 OUTBTN and OUTPLS SHALL be one-hot or zero at all times; OUTPLS SHALL be zero outside the grant cycle.
REQ-022 TMR SHALL never wrap in HOLD or COOL; transition at MAX takes precedence over increment.

Reset
REQ-023 IPTNRST=0 SHALL immediately, independent of IPTCLK, force state IDLE, TMR=0, OUTBTN=0, OUTPLS=0, OUTID=0, LAST=3.
REQ-024 Reset asserted mid-HOLD/WAITREL/COOL SHALL abort the grant with no OUTPLS and OUTBTN dropping without waiting for an edge.
REQ-025 After release of IPTNRST, first grant evaluation SHALL occur on the next rising edge; with all buttons pressed, button 0 SHALL win.

Verification
REQ-026 TIMERW=4, reset, press btn2 for 1 cycle -> OUTPLS=0100 one cycle, OUTBTN=0100 for 17 cycles, OUTBUSY high 33 cycles, OUTID=2.
REQ-027 Press btn1 held 40 cycles -> OUTBTN=0010 until edge after release, then 16 COOL cycles, then IDLE.
REQ-028 IPTBTN=1111 held across three grants -> winners 0, 1, 2 in order, each separated by release plus 16-cycle cooldown.
REQ-029 Owner btn0 in HOLD, press btn3 for 10 cycles then release -> no grant to btn3, OUTBTN stays 0001.
REQ-030 Assert IPTNRST low at TMR=7 in HOLD between edges -> OUTBTN=0000, OUTBUSY=0 immediately; after release, pressed btn3 granted in 1 cycle.
REQ-031 TIMERW=2, single 1-cycle press -> OUTBTN high exactly 5 cycles, COOL exactly 4 cycles.
